// File: rtl/fetch_unit_pkg.sv
// Shared sizing helpers for the instruction-fetch stage.
//   instr_bytes : bytes per instruction for a given XLEN
//   align_bits  : low PC bits that must be zero for an aligned instruction
//   entry_width : prefetch entry width, {pc, instr}
//   count_bits  : width of an occupancy counter that can hold 0..depth
package fetch_unit_pkg;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned instr_bytes(input int unsigned xlen);
    return xlen / BYTE_W;
  endfunction

  function automatic int unsigned align_bits(input int unsigned xlen);
    return $clog2(xlen / BYTE_W);
  endfunction

  function automatic int unsigned entry_width(input int unsigned xlen);
    return 2 * xlen;
  endfunction

  function automatic int unsigned count_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between the ROM read register and decode.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous flush (wins over push/pop)
//   push/data  : write one entry at the tail
//   pop        : retire the head entry
//   head       : entry at the head (valid when !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head,
  output logic                          full,
  output logic                          empty,
  output logic [count_bits(DEPTH)-1:0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = count_bits(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[PW'(i)] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head  = store[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencer, byte-wide ROM with registered read,
// credit-limited issue and a prefetch FIFO presenting {pc, instr} to decode.
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   redir_valid   : taken branch/jump this cycle (flushes everything in flight)
//   redir_target  : redirect byte address (aligned down before use)
//   out_ready     : decode accepts the presented instruction
//   out_valid     : out_instr/out_pc are valid
//   out_instr     : big-endian instruction word
//   out_pc        : byte address the instruction came from
//   misalign      : one-cycle pulse after a redirect with a misaligned target
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     MEM_BYTES  = 1024,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter longint unsigned RESET_PC   = 0,
  parameter string           INIT_FILE  = "data"
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            misalign
);

  localparam int unsigned IB  = instr_bytes(XLEN);
  localparam int unsigned AB  = align_bits(XLEN);
  localparam int unsigned MAW = $clog2(MEM_BYTES);
  localparam int unsigned EW  = entry_width(XLEN);
  localparam int unsigned CW  = count_bits(FIFO_DEPTH);
  localparam int unsigned DW  = CW + 1;

  // Instruction ROM.
  logic [7:0] mem [MEM_BYTES];

  logic [XLEN-1:0] fpc, fpc_d;
  logic            inflight, inflight_d;
  logic [XLEN-1:0] rd_instr, rd_instr_d;
  logic [XLEN-1:0] rd_pc, rd_pc_d;
  logic            misalign_d;

  logic [XLEN-1:0] rom_word_c;
  logic [DW-1:0]   demand_c;
  logic            issue_c;
  logic            push_c;
  logic            pop_c;

  logic [EW-1:0]   fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Assemble a big-endian word; each byte address wraps modulo MEM_BYTES.
  always_comb begin
    rom_word_c = '0;
    for (int unsigned k = 0; k < IB; k++) begin
      rom_word_c[(IB - 1 - k) * 8 +: 8] = mem[MAW'(fpc[MAW-1:0] + MAW'(k))];
    end
  end

  assign pop_c  = out_valid & out_ready;
  // A redirect squashes the returning read instead of pushing it.
  assign push_c = inflight & ~redir_valid;

  // Entries held plus the read in flight, minus what decode takes now,
  // must leave room for the read issued this cycle.
  assign demand_c = DW'(fifo_count) + DW'(inflight) - DW'(pop_c);
  assign issue_c  = ~redir_valid & (~fifo_full | pop_c) &
                    (demand_c < DW'(FIFO_DEPTH));

  // Next-state for PC sequencer and read register.
  always_comb begin
    fpc_d      = fpc;
    inflight_d = 1'b0;
    rd_instr_d = rd_instr;
    rd_pc_d    = rd_pc;
    misalign_d = 1'b0;
    if (redir_valid) begin
      fpc_d      = {redir_target[XLEN-1:AB], {AB{1'b0}}};
      misalign_d = |redir_target[AB-1:0];
    end else if (issue_c) begin
      fpc_d      = fpc + XLEN'(IB);
      inflight_d = 1'b1;
      rd_instr_d = rom_word_c;
      rd_pc_d    = fpc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fpc      <= XLEN'(RESET_PC);
      inflight <= 1'b0;
      rd_instr <= '0;
      rd_pc    <= '0;
      misalign <= 1'b0;
    end else begin
      fpc      <= fpc_d;
      inflight <= inflight_d;
      rd_instr <= rd_instr_d;
      rd_pc    <= rd_pc_d;
      misalign <= misalign_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .clear     (redir_valid),
    .push      (push_c),
    .push_data ({rd_pc, rd_instr}),
    .pop       (pop_c),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_pc    = fifo_head[EW-1:XLEN];
  assign out_instr = fifo_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign;

  logic        w_redir_valid = 1'b0;
  logic [31:0] w_redir_target = '0;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic        w_misalign;

  logic [7:0]  image [MEM_BYTES];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(32), .MEM_BYTES(MEM_BYTES), .FIFO_DEPTH(DEPTH), .RESET_PC(0), .INIT_FILE("")
  ) dut (
    .CLK(clk), .RST(rst), .redir_valid(redir_valid), .redir_target(redir_target),
    .out_ready(out_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .misalign(misalign)
  );

  // Second instance starting two bytes below the top of memory.
  fetch_unit #(
    .XLEN(32), .MEM_BYTES(MEM_BYTES), .FIFO_DEPTH(DEPTH), .RESET_PC(MEM_BYTES - 2), .INIT_FILE("")
  ) dut_wrap (
    .CLK(clk), .RST(rst), .redir_valid(w_redir_valid), .redir_target(w_redir_target),
    .out_ready(out_ready), .out_valid(w_out_valid), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .misalign(w_misalign)
  );

  // Reference: big-endian word at address a, byte addresses wrapping modulo memory size.
  function automatic logic [31:0] ref_instr(input logic [31:0] a);
    logic [31:0] w;
    logic [9:0]  idx;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = 10'(a + 32'(k));
      w = {w[23:0], image[idx]};
    end
    return w;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redir_valid = 1'b0;
    out_ready = 1'b0;
    advance();
    advance();
  endtask

  task automatic test_reset();
    advance();
    advance();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b instr=%h pc=%h mis=%b, want 0/0/0/0",
               out_valid, out_instr, out_pc, misalign);
    end
    checks++;
    if (w_out_valid !== 1'b0 || w_out_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_state_wrap: valid=%b pc=%h, want 0/0", w_out_valid, w_out_pc);
    end
  endtask

  task automatic test_first_fetch(input string name);
    out_ready = 1'b1;
    rst = 1'b0;
    advance();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_edge1: valid=%b want 0", name, out_valid);
    end
    advance();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00112233) begin
      errors++;
      $display("FAIL %s_edge2: valid=%b pc=%h instr=%h want 1/00000000/00112233",
               name, out_valid, out_pc, out_instr);
    end
    advance();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h44556677) begin
      errors++;
      $display("FAIL %s_edge3: valid=%b pc=%h instr=%h want 1/00000004/44556677",
               name, out_valid, out_pc, out_instr);
    end
    exp_pc = 32'h8;
    for (int i = 0; i < 8; i++) begin
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== ref_instr(exp_pc)) begin
        errors++;
        $display("FAIL %s_stream: valid=%b pc=%h instr=%h want 1/%h/%h",
                 name, out_valid, out_pc, out_instr, exp_pc, ref_instr(exp_pc));
      end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      advance();
      checks++;
      if (i == 0) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stall_edge1: valid=%b want 0", out_valid);
        end
      end else if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00112233) begin
        errors++;
        $display("FAIL stall_hold: cycle=%0d valid=%b pc=%h instr=%h want 1/0/00112233",
                 i, out_valid, out_pc, out_instr);
      end
    end
    checks++;
    if (dut.fifo_count !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL stall_count: got %0d want %0d", dut.fifo_count, DEPTH);
    end
    checks++;
    if (dut.fpc !== 32'(4 * DEPTH)) begin
      errors++;
      $display("FAIL stall_fpc: got %h want %h", dut.fpc, 32'(4 * DEPTH));
    end
    // Release: full throughput, pcs in order with none lost or repeated.
    out_ready = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== ref_instr(exp_pc)) begin
        errors++;
        $display("FAIL drain: valid=%b pc=%h instr=%h want 1/%h/%h",
                 out_valid, out_pc, out_instr, exp_pc, ref_instr(exp_pc));
      end
      exp_pc += 32'd4;
      advance();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    rst = 1'b0;
    repeat (4) advance();
    checks++;
    if (dut.fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL redir_setup_count: got %0d want 3", dut.fifo_count);
    end
    redir_valid = 1'b1;
    redir_target = 32'h100;
    advance();
    redir_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL redir_e1: valid=%b mis=%b want 0/0", out_valid, misalign);
    end
    advance();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_e2: valid=%b want 0", out_valid);
    end
    out_ready = 1'b1;
    advance();
    exp_pc = 32'h100;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== ref_instr(exp_pc)) begin
        errors++;
        $display("FAIL redir_stream: valid=%b pc=%h instr=%h want 1/%h/%h",
                 out_valid, out_pc, out_instr, exp_pc, ref_instr(exp_pc));
      end
      exp_pc += 32'd4;
      advance();
    end
  endtask

  task automatic test_misalign();
    out_ready = 1'b1;
    redir_valid = 1'b1;
    redir_target = 32'h102;
    advance();
    redir_valid = 1'b0;
    checks++;
    if (misalign !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: mis=%b valid=%b want 1/0", misalign, out_valid);
    end
    advance();
    checks++;
    if (misalign !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: mis=%b valid=%b want 0/0", misalign, out_valid);
    end
    advance();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== ref_instr(32'h100)) begin
      errors++;
      $display("FAIL misalign_resume: valid=%b pc=%h instr=%h want 1/00000100/%h",
               out_valid, out_pc, out_instr, ref_instr(32'h100));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] top_word;
    top_word = {image[MEM_BYTES-2], image[MEM_BYTES-1], image[0], image[1]};
    do_reset();
    out_ready = 1'b1;
    rst = 1'b0;
    advance();
    advance();
    checks++;
    if (w_out_valid !== 1'b1 || w_out_pc !== 32'h3FE || w_out_instr !== top_word) begin
      errors++;
      $display("FAIL wrap_straddle: valid=%b pc=%h instr=%h want 1/000003fe/%h",
               w_out_valid, w_out_pc, w_out_instr, top_word);
    end
    advance();
    checks++;
    if (w_out_valid !== 1'b1 || w_out_pc !== 32'h402 || w_out_instr !== ref_instr(32'h2)) begin
      errors++;
      $display("FAIL wrap_next: valid=%b pc=%h instr=%h want 1/00000402/%h",
               w_out_valid, w_out_pc, w_out_instr, ref_instr(32'h2));
    end
    // PC register wraps modulo 2^32.
    redir_valid = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    advance();
    redir_valid = 1'b0;
    advance();
    advance();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== ref_instr(32'h3FC)) begin
      errors++;
      $display("FAIL pc_wrap_top: valid=%b pc=%h instr=%h want 1/fffffffc/%h",
               out_valid, out_pc, out_instr, ref_instr(32'h3FC));
    end
    advance();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00112233) begin
      errors++;
      $display("FAIL pc_wrap_zero: valid=%b pc=%h instr=%h want 1/00000000/00112233",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    rst = 1'b0;
    repeat (6) advance();
    checks++;
    if (dut.fifo_count !== 3'(DEPTH) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_setup: count=%0d valid=%b want %0d/1", dut.fifo_count, out_valid, DEPTH);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: valid=%b pc=%h instr=%h mis=%b want all 0",
               out_valid, out_pc, out_instr, misalign);
    end
    advance();
    advance();
    test_first_fetch("after_async");
  endtask

  // Random back-pressure and redirects against a stream-level model:
  // accepted pcs run sequentially from the last (aligned) redirect target.
  task automatic test_random(input int n);
    int          since;
    logic        exp_mis;
    logic        held;
    logic        do_redir;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic [31:0] tgt;
    do_reset();
    rst = 1'b0;
    exp_pc = 32'h0;
    since = 0;
    exp_mis = 1'b0;
    held = 1'b0;
    held_pc = '0;
    held_instr = '0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (misalign !== exp_mis) begin
        errors++;
        $display("FAIL rnd_misalign: cycle=%0d got %b want %b", i, misalign, exp_mis);
      end
      if (since < 2) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_flush: cycle=%0d valid=%b want 0", i, out_valid);
        end
      end else if (since == 2) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL rnd_latency: cycle=%0d valid=%b want 1", i, out_valid);
        end
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== held_pc || out_instr !== held_instr) begin
          errors++;
          $display("FAIL rnd_stable: cycle=%0d valid=%b pc=%h instr=%h want 1/%h/%h",
                   i, out_valid, out_pc, out_instr, held_pc, held_instr);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      do_redir = ($urandom_range(0, 19) == 0);
      if (out_valid && out_ready) begin
        checks++;
        if (out_pc !== exp_pc || out_instr !== ref_instr(exp_pc)) begin
          errors++;
          $display("FAIL rnd_order: cycle=%0d pc=%h instr=%h want %h/%h",
                   i, out_pc, out_instr, exp_pc, ref_instr(exp_pc));
        end
        exp_pc += 32'd4;
      end
      held = out_valid && !out_ready && !do_redir;
      held_pc = out_pc;
      held_instr = out_instr;
      if (do_redir) begin
        tgt = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h3FF);
        redir_valid = 1'b1;
        redir_target = tgt;
        exp_pc = tgt & 32'hFFFF_FFFC;
        exp_mis = (tgt[1:0] != 2'b00);
        since = 0;
      end else begin
        redir_valid = 1'b0;
        exp_mis = 1'b0;
        if (since < 3) since++;
      end
      advance();
    end
    redir_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      image[i] = (i < 8) ? 8'(i * 8'h11) : 8'($urandom());
    end
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      dut.mem[i] = image[i];
      dut_wrap.mem[i] = image[i];
    end
    test_reset();
    test_first_fetch("first_fetch");
    test_backpressure();
    test_redirect();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
